// File: rtl/ide_device.sv
// Single-drive IDE task-file device with a 256x16 sector buffer shared with a block backend.
// Latency: register writes commit one cycle after the write strobe rises; reads are combinational.
// Backpressure: BSY holds the host off while a sector request waits for blk_ack; DRQ paces data words.
module ide_device #(
   parameter int PRESENT = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ide_cs,
   input  logic        ide_rd,
   input  logic        ide_wr,
   input  logic [2:0]  ide_addr,
   input  logic [15:0] ide_din,
   output logic [15:0] ide_dout,
   output logic        blk_req,
   output logic        blk_wr,
   output logic [27:0] blk_lba,
   input  logic        blk_ack,
   input  logic        blk_err,
   input  logic [7:0]  buf_addr,
   input  logic [15:0] buf_din,
   input  logic        buf_we,
   output logic [15:0] buf_dout
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_XFER, WR_XFER, WR_REQ} state_t;

   localparam logic PRES = (PRESENT != 0);

   state_t      state, state_nx;
   logic [15:0] buffer [0:255];
   logic [7:0]  ptr;
   logic [7:0]  features, error_reg, count;
   logic [27:0] lba;
   logic        dev_lba, dev_sel, err_flag;

   logic        acc_rd, acc_wr, acc_any, acc_prev, wr_prev;
   logic [2:0]  acc_addr;
   logic        wr_rise, acc_fall, ptr_step, sector_wrap;
   logic        tf_wr, cmd_wr, host_buf_we;
   logic [7:0]  count_dec;
   logic        set_err, clr_err, sector_adv, ptr_clr;
   logic [7:0]  err_code;
   logic        bsy, drq;
   logic [7:0]  status_byte, device_byte;

   assign acc_rd   = ide_cs & ide_rd;
   assign acc_wr   = ide_cs & ide_wr;
   assign acc_any  = acc_rd | acc_wr;
   // A write commits once, on the first cycle its strobe is seen high.
   assign wr_rise  = acc_wr & ~wr_prev & PRES;
   assign acc_fall = acc_prev & ~acc_any;
   assign ptr_step = acc_fall & (acc_addr == 3'd0) & PRES &
                     ((state == RD_XFER) | (state == WR_XFER));
   assign sector_wrap = ptr_step & (ptr == 8'hFF);
   assign tf_wr    = wr_rise & (state == IDLE) & (ide_addr != 3'd0) & (ide_addr != 3'd7);
   assign cmd_wr   = wr_rise & (state == IDLE) & (ide_addr == 3'd7) & ~dev_sel;
   assign host_buf_we = wr_rise & (state == WR_XFER) & (ide_addr == 3'd0);
   assign count_dec = count - 8'd1;

   assign bsy = (state == RD_REQ) | (state == WR_REQ);
   assign drq = (state == RD_XFER) | (state == WR_XFER);
   assign status_byte = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err_flag};
   assign device_byte = {1'b1, dev_lba, 1'b1, dev_sel, lba[27:24]};

   assign blk_req  = bsy;
   assign blk_wr   = (state == WR_REQ);
   assign blk_lba  = lba;
   assign buf_dout = buffer[buf_addr];

   // Strobe history for edge detection and the address of the access in progress.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         acc_prev <= 1'b0;
         wr_prev  <= 1'b0;
         acc_addr <= 3'd0;
      end else begin
         acc_prev <= acc_any;
         wr_prev  <= acc_wr;
         if (acc_any) acc_addr <= ide_addr;
      end
   end

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and the side effects each transition requests.
   always_comb begin
      state_nx   = state;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      err_code   = 8'h00;
      sector_adv = 1'b0;
      ptr_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_wr) begin
               clr_err = 1'b1;
               if (ide_din[7:0] == 8'h20) begin
                  state_nx = RD_REQ;
               end else if (ide_din[7:0] == 8'h30) begin
                  state_nx = WR_XFER;
                  ptr_clr  = 1'b1;
               end else begin
                  set_err  = 1'b1;
                  err_code = 8'h04;
               end
            end
         end
         RD_REQ: begin
            if (blk_ack) begin
               if (blk_err) begin
                  set_err  = 1'b1;
                  err_code = 8'h40;
                  state_nx = IDLE;
               end else begin
                  state_nx = RD_XFER;
                  ptr_clr  = 1'b1;
               end
            end
         end
         RD_XFER: begin
            if (sector_wrap) begin
               sector_adv = 1'b1;
               state_nx   = (count_dec == 8'd0) ? IDLE : RD_REQ;
            end
         end
         WR_XFER: begin
            if (sector_wrap) state_nx = WR_REQ;
         end
         WR_REQ: begin
            if (blk_ack) begin
               if (blk_err) begin
                  set_err  = 1'b1;
                  err_code = 8'h40;
                  state_nx = IDLE;
               end else begin
                  sector_adv = 1'b1;
                  ptr_clr    = 1'b1;
                  state_nx   = (count_dec == 8'd0) ? IDLE : WR_XFER;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Task-file registers, error state and the data word pointer.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         features  <= 8'h00;
         error_reg <= 8'h01;
         count     <= 8'h01;
         lba       <= 28'h0000001;
         dev_lba   <= 1'b0;
         dev_sel   <= 1'b0;
         err_flag  <= 1'b0;
         ptr       <= 8'd0;
      end else begin
         if (tf_wr) begin
            case (ide_addr)
               3'd1: features     <= ide_din[7:0];
               3'd2: count        <= ide_din[7:0];
               3'd3: lba[7:0]     <= ide_din[7:0];
               3'd4: lba[15:8]    <= ide_din[7:0];
               3'd5: lba[23:16]   <= ide_din[7:0];
               3'd6: begin
                  lba[27:24] <= ide_din[3:0];
                  dev_lba    <= ide_din[6];
                  dev_sel    <= ide_din[4];
               end
               default: ;
            endcase
         end
         if (sector_adv) begin
            lba   <= lba + 28'd1;
            count <= count_dec;
         end
         if (clr_err) err_flag <= 1'b0;
         if (set_err) begin
            err_flag  <= 1'b1;
            error_reg <= err_code;
         end
         if (ptr_clr)       ptr <= 8'd0;
         else if (ptr_step) ptr <= ptr + 8'd1;
      end
   end

   // Sector buffer; host writes only in WR_XFER, backend writes only while the host is idle.
   always_ff @(posedge clk_sys) begin
      if (host_buf_we && !reset) buffer[ptr] <= ide_din;
      else if (buf_we)           buffer[buf_addr] <= buf_din;
   end

   // Host read mux, decoded from the address alone.
   always_comb begin
      ide_dout = 16'hFFFF;
      case (ide_addr)
         3'd0: ide_dout = (state == RD_XFER) ? buffer[ptr] : 16'hFFFF;
         3'd1: ide_dout = {error_reg, error_reg};
         3'd2: ide_dout = {count, count};
         3'd3: ide_dout = {lba[7:0], lba[7:0]};
         3'd4: ide_dout = {lba[15:8], lba[15:8]};
         3'd5: ide_dout = {lba[23:16], lba[23:16]};
         3'd6: ide_dout = {device_byte, device_byte};
         3'd7: ide_dout = {status_byte, status_byte};
         default: ide_dout = 16'hFFFF;
      endcase
      if (dev_sel) ide_dout = 16'h0000;
      if (!PRES)   ide_dout = 16'hFFFF;
   end

endmodule

// File: doc/ide_device.md
IDE_DEVICE -- requirements
Module: ide_device

Interface
REQ-001 SHALL have parameter PRESENT, default 1, meaning master drive attached (0: all reads 0xFFFF, writes ignored).
REQ-002 SHALL have port clk_sys  in  1  system clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high; clock clk_sys.
REQ-004 SHALL have ports ide_cs in 1 (device select), ide_rd in 1 (read strobe), ide_wr in 1 (write strobe) and ide_addr in 3 (task-file register).
REQ-005 SHALL have ports ide_din  in  16  host write data, and ide_dout  out  16  host read data.
REQ-006 SHALL have ports blk_req out 1 (sector transfer request), blk_wr out 1 (1 = write to media), blk_lba out 28 (sector LBA), blk_ack in 1 (one-cycle done pulse) and blk_err in 1 (media error, valid with blk_ack).
REQ-007 SHALL have ports buf_addr in 8 (backend word index), buf_din in 16, buf_we in 1 and buf_dout out 16 (backend sector-buffer port).

Function
REQ-008 SHALL decode ide_addr as: 0 data, 1 error(r)/features(w), 2 sector count, 3-5 LBA[7:0]/[15:8]/[23:16], 6 device (bit6 LBA, bit4 DEV, [3:0] LBA[27:24]), 7 status(r)/command(w).
REQ-009 SHALL return 8-bit registers replicated on both ide_dout byte lanes, combinationally from ide_addr; device reads return value with bits 7 and 5 forced to 1.
REQ-010 SHALL commit a register write in the cycle after ide_cs&ide_wr rises, taking ide_din[7:0]; data writes take all 16 bits.
REQ-011 SHALL advance the data word pointer on the falling edge of ide_cs&ide_rd or ide_cs&ide_wr when the access was to address 0.
REQ-012 SHALL form status as BSY[7], DRDY[6], DSC[4], DRQ[3], ERR[0]; idle status 0x50, 0x51 when ERR set.
REQ-013 SHALL implement states IDLE, RD_REQ, RD_XFER, WR_XFER, WR_REQ.
REQ-014 IDLE: command 0x20 -> RD_REQ; command 0x30 -> WR_XFER (pointer 0); other command -> ERR=1, error=0x04, stay IDLE; any command clears ERR first.
REQ-015 RD_REQ: BSY=1, blk_req=1, blk_wr=0 until blk_ack; ack without error -> RD_XFER, pointer 0.
REQ-016 RD_XFER: DRQ=1, ide_dout = buffer[pointer]; pointer wrap 255->0 ends sector.
REQ-017 WR_XFER: DRQ=1, data writes store into buffer[pointer]; wrap ends sector -> WR_REQ.
REQ-018 WR_REQ: BSY=1, blk_req=1, blk_wr=1 until blk_ack.
REQ-019 At sector end, SHALL increment the 28-bit LBA (wrap to 0) and decrement the count; count 0 -> IDLE, else RD_REQ/WR_XFER. Initial count 0 SHALL mean 256 sectors.
REQ-020 blk_ack with blk_err SHALL set ERR=1, error=0x40 and go to IDLE, leaving LBA and count at the failing sector.
REQ-021 blk_lba SHALL equal the task-file LBA; blk_req SHALL drop in the cycle after blk_ack.
REQ-022 Task-file and command writes SHALL be ignored outside IDLE; data writes outside WR_XFER and data-pointer advance outside XFER states SHALL be ignored; data reads outside RD_XFER return 0xFFFF.
REQ-023 With device bit4=1, reads SHALL return 0x0000 and command writes SHALL be ignored; device-register writes remain accepted.
REQ-024 Backend buffer port SHALL read combinationally and write on buf_we, sharing the 256x16 buffer; host and backend accesses SHALL never be simultaneous by construction of the state machine.

Reset
REQ-025 Reset SHALL force IDLE, blk_req=0, blk_wr=0, status 0x50, error 0x01, count 0x01, LBA 0x0000001, device 0x00, features 0x00, pointer 0, ERR=0.
REQ-026 Reset mid-transfer SHALL abort in the same cycle, with blk_req low in the cycle after reset is sampled.

Verification
REQ-027 Reset, read addr 7 -> 0x5050; addr 2 -> 0x0101; addr 6 -> 0xA0A0.
REQ-028 LBA=0x0000010, count=2, cmd 0x20 -> blk_req with blk_lba=0x10; ack -> 256 reads return buffer words, then blk_lba=0x11; after 2nd sector status 0x50, count 0.
REQ-029 cmd 0x30, count=1, 256 data writes of i -> WR_REQ with blk_wr=1; buf_dout at buf_addr 5 = 0x0005; ack -> status 0x50.
REQ-030 cmd 0x20, ack with blk_err -> status 0x51, error 0x40, no DRQ.
REQ-031 cmd 0xEC -> status 0x51, error 0x04; next cmd 0x20 clears ERR and status reads 0xD0 (BSY|DRDY).
REQ-032 Reset asserted in RD_XFER after 10 words -> status 0x50, pointer 0, blk_req 0.
